// File: rtl/xilinx_pcie_pkg.sv
// Shared TLP format/type codes, RX decoder state encoding and header field helpers.
// PCIE_RX_MEM64_EN adds the MWR64_DW state used by 4DW-header memory writes.
package xilinx_pcie_pkg;

  localparam logic [6:0] MRD32 = 7'h00;
  localparam logic [6:0] MRD64 = 7'h20;
  localparam logic [6:0] MWR32 = 7'h40;
  localparam logic [6:0] MWR64 = 7'h60;
  localparam logic [6:0] CPL   = 7'h0A;
  localparam logic [6:0] CPLD  = 7'h4A;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CPL = 3'd1,
    ST_WAIT_WR  = 3'd2,
    ST_DISCARD  = 3'd3
`ifdef PCIE_RX_MEM64_EN
    , ST_MWR64_DW = 3'd4
`endif
  } rx_state_e;

  typedef struct packed {
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
  } rx_req_t;

  function automatic logic [6:0] hdr_fmt(input logic [31:0] dw0);
    return dw0[30:24];
  endfunction

  function automatic rx_req_t hdr_req(input logic [63:0] dw10);
    rx_req_t r;
    r.tc   = dw10[22:20];
    r.td   = dw10[15];
    r.ep   = dw10[14];
    r.attr = dw10[13:12];
    r.len  = dw10[9:0];
    r.rid  = dw10[63:48];
    r.tag  = dw10[47:40];
    r.be   = dw10[39:32];
    return r;
  endfunction

endpackage

// File: rtl/xilinx_pcie_rx_decode_if.sv
// AXI4-Stream RX beat bundle from the PCIe core towards the TLP decoder.
interface xilinx_pcie_rx_decode_if #(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
);
  logic [P_DATA_WIDTH-1:0] m_axis_rx_tdata;
  logic [P_KEEP_WIDTH-1:0] m_axis_rx_tkeep;
  logic                    m_axis_rx_tlast;
  logic                    m_axis_rx_tvalid;
  logic                    m_axis_rx_tready;

  modport master (
    output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
    input  m_axis_rx_tready
  );

  modport slave (
    input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast, m_axis_rx_tvalid,
    output m_axis_rx_tready
  );
endinterface

// File: rtl/xilinx_pcie_rx_decode.sv
// PIO-style RX TLP decoder: MRd -> completion request, single-DW MWr -> write strobe.
// Define PCIE_RX_MEM64_EN to also decode 4DW-header MRd64/MWr64.
module xilinx_pcie_rx_decode
  import xilinx_pcie_pkg::*;
#(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  xilinx_pcie_rx_decode_if.slave        rx,
  output logic                          req_compl,
  output logic                          req_compl_wd,
  input  logic                          compl_done,
  output logic [2:0]                    req_tc,
  output logic                          req_td,
  output logic                          req_ep,
  output logic [1:0]                    req_attr,
  output logic [9:0]                    req_len,
  output logic [15:0]                   req_rid,
  output logic [7:0]                    req_tag,
  output logic [7:0]                    req_be,
  output logic [31:0]                   req_addr,
  output logic                          wr_en,
  output logic [31:0]                   wr_addr,
  output logic [3:0]                    wr_be,
  output logic [31:0]                   wr_data,
  input  logic                          wr_busy
);

  rx_state_e   state_q, state_d;
  logic        tready_q, tready_d;
  logic        req_compl_q, req_compl_d;
  logic        req_wd_q, req_wd_d;
  rx_req_t     req_q, req_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [3:0]  wr_be_q, wr_be_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic [P_DATA_WIDTH-1:0] beat_data;
  logic [P_KEEP_WIDTH-1:0] unused_tkeep;
  logic                    unused_bits;
  logic                    beat;
  logic [6:0]              fmt;
  rx_req_t                 hdr;
  logic [31:0]             dw2, dw3;

  assign beat_data    = rx.m_axis_rx_tdata;
  assign unused_tkeep = rx.m_axis_rx_tkeep;
  assign unused_bits  = ^{unused_tkeep, beat_data[31], beat_data[23], beat_data[19:16],
                          beat_data[11:10], beat_data[65:64]};

  assign beat = rx.m_axis_rx_tvalid && tready_q;
  assign fmt  = hdr_fmt(beat_data[31:0]);
  assign hdr  = hdr_req(beat_data[63:0]);
  assign dw2  = beat_data[95:64];
  assign dw3  = beat_data[127:96];

  always_comb begin
    state_d     = state_q;
    req_compl_d = 1'b0;
    req_wd_d    = req_wd_q;
    req_d       = req_q;
    req_addr_d  = req_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_be_d     = wr_be_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (beat) begin
          if (fmt == MRD32) begin
            req_d       = hdr;
            req_addr_d  = {dw2[31:2], 2'b00};
            req_wd_d    = 1'b1;
            req_compl_d = 1'b1;
            state_d     = ST_WAIT_CPL;
          end else if (fmt == MWR32 && hdr.len == 10'd1) begin
            wr_addr_d = {dw2[31:2], 2'b00};
            wr_be_d   = hdr.be[3:0];
            wr_data_d = dw3;
            state_d   = ST_WAIT_WR;
          end
`ifdef PCIE_RX_MEM64_EN
          // 4DW headers: only a 32-bit address (upper DW zero) is serviceable
          else if (fmt == MRD64 && dw2 == '0) begin
            req_d       = hdr;
            req_addr_d  = {dw3[31:2], 2'b00};
            req_wd_d    = 1'b1;
            req_compl_d = 1'b1;
            state_d     = ST_WAIT_CPL;
          end else if (fmt == MWR64 && hdr.len == 10'd1) begin
            wr_addr_d = {dw3[31:2], 2'b00};
            wr_be_d   = hdr.be[3:0];
            state_d   = ST_MWR64_DW;
          end
`endif
          else if (!rx.m_axis_rx_tlast) begin
            state_d = ST_DISCARD;
          end
        end
      end
`ifdef PCIE_RX_MEM64_EN
      ST_MWR64_DW: begin
        if (beat) begin
          wr_data_d = beat_data[31:0];
          state_d   = ST_WAIT_WR;
        end
      end
`endif
      ST_WAIT_CPL: begin
        if (compl_done) state_d = ST_IDLE;
      end
      ST_WAIT_WR: begin
        if (!wr_busy) state_d = ST_IDLE;
      end
      ST_DISCARD: begin
        if (beat && rx.m_axis_rx_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Moore outputs are registered from the next state so they track state_q exactly
    tready_d = (state_d == ST_IDLE) || (state_d == ST_DISCARD)
`ifdef PCIE_RX_MEM64_EN
               || (state_d == ST_MWR64_DW)
`endif
               ;
    wr_en_d  = (state_d == ST_WAIT_WR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      tready_q    <= 1'b0;
      req_compl_q <= 1'b0;
      req_wd_q    <= 1'b0;
      req_q       <= '0;
      req_addr_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_be_q     <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      req_compl_q <= req_compl_d;
      req_wd_q    <= req_wd_d;
      req_q       <= req_d;
      req_addr_q  <= req_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_be_q     <= wr_be_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign rx.m_axis_rx_tready = tready_q;
  assign req_compl    = req_compl_q;
  assign req_compl_wd = req_wd_q;
  assign req_tc       = req_q.tc;
  assign req_td       = req_q.td;
  assign req_ep       = req_q.ep;
  assign req_attr     = req_q.attr;
  assign req_len      = req_q.len;
  assign req_rid      = req_q.rid;
  assign req_tag      = req_q.tag;
  assign req_be       = req_q.be;
  assign req_addr     = req_addr_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_be        = wr_be_q;
  assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_xilinx_pcie_rx_decode.sv
// Randomized and directed bench for xilinx_pcie_rx_decode with a TLP-level reference model.
module tb_xilinx_pcie_rx_decode;
  import xilinx_pcie_pkg::*;

  logic clk = 1'b0, rst_n = 1'b1, compl_done = 1'b0, wr_busy = 1'b0;
  logic req_compl, req_compl_wd, req_td, req_ep, wr_en;
  logic [2:0] req_tc;
  logic [1:0] req_attr;
  logic [9:0] req_len;
  logic [15:0] req_rid;
  logic [7:0] req_tag, req_be;
  logic [31:0] req_addr, wr_addr, wr_data;
  logic [3:0] wr_be;

  int n_checks = 0, n_fail = 0;
  int n_compl = 0, n_wr = 0;

  xilinx_pcie_rx_decode_if #(.P_DATA_WIDTH(128)) rx_if ();

  xilinx_pcie_rx_decode #(.P_DATA_WIDTH(128)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .rx(rx_if),
    .req_compl(req_compl), .req_compl_wd(req_compl_wd), .compl_done(compl_done),
    .req_tc(req_tc), .req_td(req_td), .req_ep(req_ep), .req_attr(req_attr),
    .req_len(req_len), .req_rid(req_rid), .req_tag(req_tag), .req_be(req_be),
    .req_addr(req_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_data(wr_data), .wr_busy(wr_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req_compl) n_compl++;
    if (wr_en) n_wr++;
  end

  initial begin
    rx_if.m_axis_rx_tdata  = '0;
    rx_if.m_axis_rx_tkeep  = '0;
    rx_if.m_axis_rx_tlast  = 1'b0;
    rx_if.m_axis_rx_tvalid = 1'b0;
  end

  function automatic logic [127:0] make_tlp(input logic [6:0] fmt, input logic [9:0] len,
      input logic [2:0] tc, input logic td, input logic ep, input logic [1:0] attr,
      input logic [15:0] rid, input logic [7:0] tag, input logic [7:0] be,
      input logic [31:0] dw2, input logic [31:0] dw3, input logic [31:0] junk);
    logic [31:0] dw0;
    dw0 = {1'b0, fmt, 1'b0, tc, 4'b0000, td, ep, attr, 2'b00, len} | (junk & 32'h808F_0C00);
    return {dw3, dw2, rid, tag, be, dw0};
  endfunction

  // Presents one beat after `gaps` idle cycles of junk; returns 1ns after the accepting edge.
  task automatic send_beat(input logic [127:0] d, input logic last, input int gaps);
    int n;
    repeat (gaps) begin
      @(negedge clk);
      rx_if.m_axis_rx_tvalid = 1'b0;
      rx_if.m_axis_rx_tdata  = {$urandom, $urandom, $urandom, $urandom};
      rx_if.m_axis_rx_tlast  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rx_if.m_axis_rx_tdata  = d;
    rx_if.m_axis_rx_tlast  = last;
    rx_if.m_axis_rx_tkeep  = 16'($urandom);
    rx_if.m_axis_rx_tvalid = 1'b1;
    n = 0;
    while (rx_if.m_axis_rx_tready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (rx_if.m_axis_rx_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL beat_accept: tready=%b after %0d cycles, required 1", rx_if.m_axis_rx_tready, n);
    end
    @(posedge clk);
    #1;
    rx_if.m_axis_rx_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_if.m_axis_rx_tready, req_compl, req_compl_wd, wr_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: tready/req_compl/wd/wr_en=%b required 0000",
               {rx_if.m_axis_rx_tready, req_compl, req_compl_wd, wr_en});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({req_tc, req_td, req_ep, req_attr, req_len, req_rid, req_tag, req_be, req_addr,
         wr_addr, wr_be, wr_data, rx_if.m_axis_rx_tready} !== '0) begin
      n_fail++;
      $display("FAIL reset_fields: rid=%h tag=%h addr=%h wr_addr=%h wr_data=%h tready=%b required all 0",
               req_rid, req_tag, req_addr, wr_addr, wr_data, rx_if.m_axis_rx_tready);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (rx_if.m_axis_rx_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_tready: got %b required 1", rx_if.m_axis_rx_tready);
    end
  endtask

  task automatic test_mrd32();
    int c0;
    c0 = n_compl;
    send_beat(make_tlp(MRD32, 10'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'hABCD, 8'h12, 8'h0F,
                       32'h0000_0104, 32'h5555_AAAA, 32'h0), 1'b1, 0);
    n_checks++;
    if ({req_compl, req_compl_wd, rx_if.m_axis_rx_tready} !== 3'b110) begin
      n_fail++;
      $display("FAIL mrd32_pulse: compl/wd/tready=%b required 110",
               {req_compl, req_compl_wd, rx_if.m_axis_rx_tready});
    end
    n_checks++;
    if ({req_tag, req_rid, req_addr, req_be, req_len} !== {8'h12, 16'hABCD, 32'h104, 8'h0F, 10'd1}) begin
      n_fail++;
      $display("FAIL mrd32_fields: tag=%h rid=%h addr=%h be=%h len=%0d required 12 abcd 00000104 0f 1",
               req_tag, req_rid, req_addr, req_be, req_len);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({req_compl, rx_if.m_axis_rx_tready, req_tag} !== {2'b00, 8'h12}) begin
        n_fail++;
        $display("FAIL mrd32_wait[%0d]: compl=%b tready=%b tag=%h required 0 0 12",
                 i, req_compl, rx_if.m_axis_rx_tready, req_tag);
      end
    end
    n_checks++;
    if (n_compl - c0 !== 1) begin
      n_fail++;
      $display("FAIL mrd32_pulse_count: got %0d required 1", n_compl - c0);
    end
    @(negedge clk) compl_done = 1'b1;
    @(posedge clk);
    #1 compl_done = 1'b0;
    n_checks++;
    if (rx_if.m_axis_rx_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL mrd32_done_idle: tready=%b required 1", rx_if.m_axis_rx_tready);
    end
  endtask

  task automatic test_mwr32();
    int w0;
    w0 = n_wr;
    wr_busy = 1'b1;
    send_beat(make_tlp(MWR32, 10'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0001, 8'h03, 8'hFF,
                       32'h0000_0040, 32'hDEAD_BEEF, 32'h0), 1'b1, 1);
    n_checks++;
    if ({wr_en, rx_if.m_axis_rx_tready, wr_addr, wr_be, wr_data} !== {2'b10, 32'h40, 4'hF, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL mwr32_fields: wr_en=%b tready=%b addr=%h be=%h data=%h required 1 0 00000040 f deadbeef",
               wr_en, rx_if.m_axis_rx_tready, wr_addr, wr_be, wr_data);
    end
    repeat (3) @(posedge clk);
    #1 wr_busy = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({wr_en, rx_if.m_axis_rx_tready} !== 2'b01 || n_wr - w0 !== 4) begin
      n_fail++;
      $display("FAIL mwr32_busy: wr_en=%b tready=%b wr_cycles=%0d required 0 1 4",
               wr_en, rx_if.m_axis_rx_tready, n_wr - w0);
    end
  endtask

  task automatic test_unsupported();
    int c0, w0;
    c0 = n_compl;
    w0 = n_wr;
    send_beat(make_tlp(CPLD, 10'd2, 3'd1, 1'b0, 1'b0, 2'd0, 16'h1111, 8'h22, 8'hFF,
                       32'h0, 32'h0, 32'hFFFF_FFFF), 1'b0, 0);
    // middle beat looks like an MRd32 header and must not be decoded
    send_beat(make_tlp(MRD32, 10'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h7777, 8'h99, 8'h0F,
                       32'h0000_0800, 32'h0, 32'h0), 1'b0, 2);
    n_checks++;
    if (rx_if.m_axis_rx_tready !== 1'b1 || req_compl !== 1'b0) begin
      n_fail++;
      $display("FAIL discard_mid: tready=%b compl=%b required 1 0", rx_if.m_axis_rx_tready, req_compl);
    end
    send_beat({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (n_compl - c0 !== 0 || n_wr - w0 !== 0 || rx_if.m_axis_rx_tready !== 1'b1 ||
        {req_tag, req_rid, wr_data} !== {8'h12, 16'hABCD, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL discard_end: compls=%0d wrs=%0d tready=%b tag=%h rid=%h wr_data=%h required 0 0 1 12 abcd deadbeef",
               n_compl - c0, n_wr - w0, rx_if.m_axis_rx_tready, req_tag, req_rid, wr_data);
    end
  endtask

  task automatic test_mem64();
    int w0;
    w0 = n_wr;
    send_beat(make_tlp(MWR64, 10'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0002, 8'h04, 8'h0F,
                       32'h0, 32'h0000_0200, 32'h0), 1'b0, 0);
    send_beat({32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000, 32'h0123_4567}, 1'b1, 0);
`ifdef PCIE_RX_MEM64_EN
    n_checks++;
    if ({wr_en, wr_addr, wr_data, wr_be} !== {1'b1, 32'h200, 32'h0123_4567, 4'hF}) begin
      n_fail++;
      $display("FAIL mwr64_write: wr_en=%b addr=%h data=%h be=%h required 1 00000200 01234567 f",
               wr_en, wr_addr, wr_data, wr_be);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (n_wr - w0 !== 1 || rx_if.m_axis_rx_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL mwr64_count: wr_cycles=%0d tready=%b required 1 1", n_wr - w0, rx_if.m_axis_rx_tready);
    end
`else
    @(posedge clk);
    #1;
    n_checks++;
    if (n_wr - w0 !== 0 || rx_if.m_axis_rx_tready !== 1'b1 || wr_data !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mwr64_discard: wr_cycles=%0d tready=%b wr_data=%h required 0 1 deadbeef",
               n_wr - w0, rx_if.m_axis_rx_tready, wr_data);
    end
`endif
  endtask

  task automatic test_reset_wait_cpl();
    send_beat(make_tlp(MRD32, 10'd1, 3'd0, 1'b0, 1'b0, 2'd0, 16'h4321, 8'h55, 8'h0F,
                       32'h0000_0010, 32'h0, 32'h0), 1'b1, 0);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_compl, rx_if.m_axis_rx_tready, req_tag, req_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_in_wait_cpl: compl=%b tready=%b tag=%h addr=%h required 0 0 00 00000000",
               req_compl, rx_if.m_axis_rx_tready, req_tag, req_addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    send_beat(make_tlp(MRD32, 10'd4, 3'd5, 1'b1, 1'b0, 2'd2, 16'h2468, 8'h66, 8'hF3,
                       32'h0000_0A0B, 32'h0, 32'h0), 1'b1, 0);
    n_checks++;
    if ({req_compl, req_tag, req_rid, req_addr, req_len, req_tc, req_td, req_attr} !==
        {1'b1, 8'h66, 16'h2468, 32'h0000_0A08, 10'd4, 3'd5, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL post_reset_mrd: compl=%b tag=%h rid=%h addr=%h len=%0d tc=%0d td=%b attr=%0d required 1 66 2468 00000a08 4 5 1 2",
               req_compl, req_tag, req_rid, req_addr, req_len, req_tc, req_td, req_attr);
    end
    @(negedge clk) compl_done = 1'b1;
    @(posedge clk);
    #1 compl_done = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] fmt, rfmt;
    logic [9:0] len;
    logic [2:0] tc;
    logic td, ep;
    logic [1:0] attr;
    logic [15:0] rid;
    logic [7:0] tag, be;
    logic [31:0] dw2, dw3, exp_addr, exp_data;
    logic [127:0] data_beat;
    int kind, nbeats, c0, w0, b, k;
    for (int it = 0; it < 80; it++) begin
      rfmt = 7'($urandom);
      case ($urandom_range(0, 6))
        0: fmt = MRD32;
        1: fmt = MWR32;
        2: fmt = MRD64;
        3: fmt = MWR64;
        4: fmt = CPL;
        5: fmt = CPLD;
        default: fmt = rfmt;
      endcase
      len  = ($urandom_range(0, 3) != 0) ? 10'd1 : 10'($urandom_range(0, 1023));
      tc   = 3'($urandom);
      td   = 1'($urandom);
      ep   = 1'($urandom);
      attr = 2'($urandom);
      rid  = 16'($urandom);
      tag  = 8'($urandom);
      be   = 8'($urandom);
      dw2  = $urandom;
      dw3  = $urandom;
      if ((fmt == MRD64 || fmt == MWR64) && $urandom_range(0, 3) != 0) dw2 = 32'h0;
      data_beat = {$urandom, $urandom, $urandom, $urandom};

      // reference: 0 = ignored/discarded, 1 = completion request, 2 = single-DW write
      kind = 0;
      exp_data = 32'h0;
      exp_addr = 32'h0;
      if (fmt == MRD32) begin
        kind = 1; exp_addr = dw2 & 32'hFFFF_FFFC;
      end else if (fmt == MWR32 && len == 10'd1) begin
        kind = 2; exp_addr = dw2 & 32'hFFFF_FFFC; exp_data = dw3;
      end
`ifdef PCIE_RX_MEM64_EN
      else if (fmt == MRD64 && dw2 == 32'h0) begin
        kind = 1; exp_addr = dw3 & 32'hFFFF_FFFC;
      end else if (fmt == MWR64 && len == 10'd1) begin
        kind = 2; exp_addr = dw3 & 32'hFFFF_FFFC; exp_data = data_beat[31:0];
      end
`endif
      nbeats = (kind == 0) ? $urandom_range(1, 4) : ((fmt == MWR64) ? 2 : 1);

      c0 = n_compl;
      w0 = n_wr;
      send_beat(make_tlp(fmt, len, tc, td, ep, attr, rid, tag, be, dw2, dw3, $urandom),
                (nbeats == 1), $urandom_range(0, 2));
      for (int j = 1; j < nbeats; j++)
        send_beat((j == 1) ? data_beat : {$urandom, $urandom, $urandom, $urandom},
                  (j == nbeats - 1), $urandom_range(0, 2));

      if (kind == 1) begin
        n_checks++;
        if ({req_compl, req_compl_wd, rx_if.m_axis_rx_tready, req_tc, req_td, req_ep, req_attr,
             req_len, req_rid, req_tag, req_be, req_addr} !==
            {3'b110, tc, td, ep, attr, len, rid, tag, be, exp_addr}) begin
          n_fail++;
          $display("FAIL rnd_compl[%0d] fmt=%h: compl=%b wd=%b tready=%b tc=%0d td=%b ep=%b attr=%0d len=%0d rid=%h tag=%h be=%h addr=%h required 1 1 0 %0d %b %b %0d %0d %h %h %h %h",
                   it, fmt, req_compl, req_compl_wd, rx_if.m_axis_rx_tready, req_tc, req_td, req_ep,
                   req_attr, req_len, req_rid, req_tag, req_be, req_addr,
                   tc, td, ep, attr, len, rid, tag, be, exp_addr);
        end
        k = $urandom_range(1, 3);
        repeat (k) @(posedge clk);
        #1;
        n_checks++;
        if (n_compl - c0 !== 1 || req_compl !== 1'b0 || rx_if.m_axis_rx_tready !== 1'b0 ||
            {req_tag, req_rid, req_addr, req_len} !== {tag, rid, exp_addr, len}) begin
          n_fail++;
          $display("FAIL rnd_hold[%0d]: pulses=%0d compl=%b tready=%b tag=%h addr=%h required 1 0 0 %h %h",
                   it, n_compl - c0, req_compl, rx_if.m_axis_rx_tready, req_tag, req_addr, tag, exp_addr);
        end
        @(negedge clk) compl_done = 1'b1;
        @(posedge clk);
        #1 compl_done = 1'b0;
        n_checks++;
        if (rx_if.m_axis_rx_tready !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_compl_idle[%0d]: tready=%b required 1", it, rx_if.m_axis_rx_tready);
        end
      end else if (kind == 2) begin
        n_checks++;
        if ({wr_en, rx_if.m_axis_rx_tready, wr_addr, wr_be, wr_data} !==
            {2'b10, exp_addr, be[3:0], exp_data}) begin
          n_fail++;
          $display("FAIL rnd_write[%0d] fmt=%h: wr_en=%b tready=%b addr=%h be=%h data=%h required 1 0 %h %h %h",
                   it, fmt, wr_en, rx_if.m_axis_rx_tready, wr_addr, wr_be, wr_data,
                   exp_addr, be[3:0], exp_data);
        end
        b = $urandom_range(0, 2);
        if (b > 0) begin
          wr_busy = 1'b1;
          repeat (b) @(posedge clk);
          #1 wr_busy = 1'b0;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (n_wr - w0 !== b + 1 || wr_en !== 1'b0 || n_compl - c0 !== 0 ||
            rx_if.m_axis_rx_tready !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_write_len[%0d]: wr_cycles=%0d wr_en=%b compls=%0d tready=%b required %0d 0 0 1",
                   it, n_wr - w0, wr_en, n_compl - c0, rx_if.m_axis_rx_tready, b + 1);
        end
      end else begin
        @(posedge clk);
        #1;
        n_checks++;
        if (n_compl - c0 !== 0 || n_wr - w0 !== 0 || rx_if.m_axis_rx_tready !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd_ignore[%0d] fmt=%h len=%0d beats=%0d: compls=%0d wrs=%0d tready=%b required 0 0 1",
                   it, fmt, len, nbeats, n_compl - c0, n_wr - w0, rx_if.m_axis_rx_tready);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mrd32();
    test_mwr32();
    test_unsupported();
    test_mem64();
    test_reset_wait_cpl();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xilinx_pcie_rx_decode.md
XILINX_PCIE_RX_DECODE -- requirements
Module: xilinx_pcie_rx_decode

Interface
REQ-001 P_DATA_WIDTH, 128, AXIS data width (only 128 supported); P_KEEP_WIDTH, P_DATA_WIDTH/8, tkeep width.
REQ-002 One clock; reset is asynchronous and active-low; ports are i_clk and i_rst_n.
REQ-003 i_clk  in  1  clock; i_rst_n  in  1  async active-low reset.
REQ-004 m_axis_rx_tdata  in  128  RX TLP beat; DW0 = [31:0], DW3 = [127:96].
REQ-005 m_axis_rx_tkeep  in  16  byte enables; m_axis_rx_tlast  in  1  last beat; m_axis_rx_tvalid  in  1  beat valid.
REQ-006 m_axis_rx_tready  out  1  decoder can accept a beat.
REQ-007 req_compl  out  1  one-cycle completion request; req_compl_wd  out  1  completion carries data.
REQ-008 compl_done  in  1  level from completer, high once completion is launched.
REQ-009 req_tc 3, req_td 1, req_ep 1, req_attr 2, req_len 10, req_rid 16, req_tag 8, req_be 8, req_addr 32  out  captured request fields.
REQ-010 wr_en  out  1  write strobe; wr_addr  out  32  byte address ([1:0]=0); wr_be  out  4  byte enables; wr_data  out  32  data; wr_busy  in  1  write sink stall.

Function
REQ-011 Beat accepted only when m_axis_rx_tvalid && m_axis_rx_tready; m_axis_rx_tready is a Moore function of state.
REQ-012 States: IDLE, MWR64_DW, WAIT_CPL, WAIT_WR, DISCARD; tready=1 in IDLE, MWR64_DW, DISCARD; tready=0 in WAIT_CPL, WAIT_WR.
REQ-013 Header fields from first beat: fmt_type=[30:24], tc=[22:20], td=[15], ep=[14], attr=[13:12], len=[9:0], rid=[63:48], tag=[47:40], be=[39:32].
REQ-014 IDLE, MRd32 (fmt_type 7'h00): latch fields, req_addr={DW2[31:2],2'b00}, req_compl_wd=1, pulse req_compl next cycle, go WAIT_CPL.
REQ-015 Request fields stay stable from the req_compl pulse until compl_done is sampled high.
REQ-016 WAIT_CPL: on compl_done=1, go IDLE; req_compl is never re-asserted for the same TLP.
REQ-017 IDLE, MWr32 (7'h40), len=1: wr_addr={DW2[31:2],2'b00}, wr_be=be[3:0], wr_data=DW3 (no byte swap), go WAIT_WR.
REQ-018 WAIT_WR: wr_en=1; go IDLE in the cycle after wr_en=1 && wr_busy=0; wr_en=0 in all other states.
REQ-019 MWr with len!=1, any other fmt_type, or tlast=0 on an unsupported first beat: go DISCARD; unsupported single beat (tlast=1): stay IDLE.
REQ-020 DISCARD: accept beats, no outputs change, go IDLE on accepted beat with tlast=1.
REQ-021 MRd with len>1 still produces one single-DW completion with the captured len.
REQ-022 tkeep is ignored for decode; a beat with tvalid=0 never advances state.

Reset
REQ-023 i_rst_n low asynchronously forces IDLE, tready=0, req_compl=0, req_compl_wd=0, wr_en=0, all captured fields 0.
REQ-024 Reset mid-TLP or mid-WAIT_CPL drops the pending request; after release, the first accepted beat is treated as a new header.

Configuration
REQ-025 Macro PCIE_RX_MEM64_EN defined: MRd64 (7'h20) uses DW3 as req_addr (DW2 upper must be 0, else DISCARD path); MWr64 (7'h60) goes MWR64_DW, data = second-beat DW0, address from DW3.
REQ-026 PCIE_RX_MEM64_EN undefined: all 4DW-header TLPs take the REQ-019 discard path; MWR64_DW state is absent.

Structure
REQ-027 Shared package xilinx_pcie_pkg holds fmt_type constants (MRD32, MRD64, MWR32, MWR64, CPL, CPLD) and the state encoding.
REQ-028 Single module; no sub-module.

Verification
REQ-029 MRd32 beat, tag=8'h12, rid=16'hABCD, addr=32'h0000_0104, be=8'h0F -> req_compl one cycle, fields match, tready=0 until compl_done=1.
REQ-030 MWr32 addr=32'h40, data=32'hDEADBEEF, be=4'hF, wr_busy high 3 cycles -> wr_en held 4 cycles, then IDLE, tready=1.
REQ-031 3-beat unsupported TLP (fmt_type 7'h4A) -> no req_compl/wr_en, IDLE after third beat with tlast.
REQ-032 With PCIE_RX_MEM64_EN: MWr64 addr=32'h0000_0200, second beat DW0=32'h0123_4567 -> one write; without macro -> discarded.
REQ-033 i_rst_n asserted in WAIT_CPL -> req_compl=0, tready=0 at once; next MRd after release processed normally.
